// File: rtl/bcd_serial_adder_if.sv
// Handshake and result bundle for the digit-serial BCD adder.
// The master drives the operands and the start request. The slave
// (the adder) returns status, the packed-BCD result and the segment patterns.
interface bcd_serial_adder_if #(
    parameter int DIGITS = 4
);
    logic                     start;
    logic                     cin;
    logic [4*DIGITS-1:0]      a;
    logic [4*DIGITS-1:0]      b;
    logic                     ready;
    logic                     busy;
    logic                     done;
    logic [4*DIGITS-1:0]      sum;
    logic                     cout;
    logic                     err;
    logic [7*(DIGITS+1)-1:0]  seg;

    modport master (
        output start, cin, a, b,
        input  ready, busy, done, sum, cout, err, seg
    );

    modport slave (
        input  start, cin, a, b,
        output ready, busy, done, sum, cout, err, seg
    );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, least significant digit first.
// One digit is added per clock in ADD. The decimal carry is held in a
// register between digits. Results and the DIGITS+1 seven-segment patterns
// (carry digit on top, 'E' on digits with a non-BCD input nibble) are
// updated together on the edge that raises done.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    bcd_serial_adder_if.slave bus
);
    localparam int W     = 4 * DIGITS;
    localparam int SW    = 7 * (DIGITS + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    // Working registers: operands shift right one digit per step, and the
    // sum fills in from the top so digit 0 lands at the bottom at the end.
    logic [W-1:0]       a_w;
    logic [W-1:0]       b_w;
    logic [W-1:0]       sum_w;
    logic [DIGITS-1:0]  errd_w;
    logic               c_w;
    logic               err_w;
    logic [IDX_W-1:0]   idx;

    // Held result registers
    logic [W-1:0]       sum_r;
    logic               cout_r;
    logic               err_r;
    logic [SW-1:0]      seg_r;

    // Single-digit step signals
    logic [3:0]         a_i;
    logic [3:0]         b_i;
    logic [4:0]         t;
    logic [4:0]         t_corr;
    logic [3:0]         dig;
    logic               c_nx;
    logic               derr;
    logic [W-1:0]       dig_ext;
    logic [W-1:0]       sum_nx;
    logic [DIGITS-1:0]  derr_ext;
    logic [DIGITS-1:0]  errd_nx;
    logic [SW-1:0]      seg_nx;

    logic               accept;
    logic               last;

    // Active-low gfedcba pattern for one decimal digit; non-decimal shows 'E'.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h06;
        endcase
        return s;
    endfunction

    assign accept = ((state == IDLE) || (state == DONE)) && bus.start;
    assign last   = (idx == IDX_W'(DIGITS - 1));

    // One decimal digit addition plus the next working-register contents,
    // including the segment patterns used when this is the final digit.
    always_comb begin
        a_i    = a_w[3:0];
        b_i    = b_w[3:0];
        t      = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_w};
        t_corr = t + 5'd6;
        dig    = t[3:0];
        c_nx   = 1'b0;
        if (t > 5'd9) begin
            dig  = t_corr[3:0];
            c_nx = 1'b1;
        end
        derr = (a_i > 4'd9) || (b_i > 4'd9);

        dig_ext      = '0;
        dig_ext[3:0] = dig;
        sum_nx       = (sum_w >> 4) | (dig_ext << (W - 4));

        derr_ext    = '0;
        derr_ext[0] = derr;
        errd_nx     = (errd_w >> 1) | (derr_ext << (DIGITS - 1));

        seg_nx = '1;
        for (int k = 0; k < DIGITS; k++) begin
            seg_nx[7*k +: 7] = errd_nx[k] ? 7'h06 : seg_decode(sum_nx[4*k +: 4]);
        end
        seg_nx[7*DIGITS +: 7] = c_nx ? 7'h79 : 7'h40;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = ADD;
            ADD:     if (last) state_nx = DONE;
            DONE:    state_nx = bus.start ? ADD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Working registers: latch operands on accept, step one digit per ADD cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_w    <= '0;
            b_w    <= '0;
            sum_w  <= '0;
            errd_w <= '0;
            c_w    <= 1'b0;
            err_w  <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            a_w    <= bus.a;
            b_w    <= bus.b;
            sum_w  <= '0;
            errd_w <= '0;
            c_w    <= bus.cin;
            err_w  <= 1'b0;
            idx    <= '0;
        end else if (state == ADD) begin
            a_w    <= a_w >> 4;
            b_w    <= b_w >> 4;
            sum_w  <= sum_nx;
            errd_w <= errd_nx;
            c_w    <= c_nx;
            err_w  <= err_w | derr;
            idx    <= idx + 1'b1;
        end
    end

    // Result registers: change only on the edge that raises done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
            err_r  <= 1'b0;
            seg_r  <= '1;
        end else if ((state == ADD) && last) begin
            sum_r  <= sum_nx;
            cout_r <= c_nx;
            err_r  <= err_w | derr;
            seg_r  <= seg_nx;
        end
    end

    assign bus.ready = (state == IDLE) || (state == DONE);
    assign bus.busy  = (state == ADD);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_r;
    assign bus.cout  = cout_r;
    assign bus.err   = err_r;
    assign bus.seg   = seg_r;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder: a 4-digit instance and a 1-digit instance
// share the clock and reset; expected values are hand-computed constants.
module tb_bcd_serial_adder;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   n;
    int   seen;

    bcd_serial_adder_if #(.DIGITS(4)) if4 ();
    bcd_serial_adder_if #(.DIGITS(1)) if1 ();

    bcd_serial_adder #(.DIGITS(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4.slave)
    );

    bcd_serial_adder #(.DIGITS(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op4(input logic [15:0] a, input logic [15:0] b, input logic ci);
        if4.a     = a;
        if4.b     = b;
        if4.cin   = ci;
        if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
    endtask

    task automatic wait_done4(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!if4.done && cnt < 20);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        if4.start = 1'b0; if4.cin = 1'b0; if4.a = '0; if4.b = '0;
        if1.start = 1'b0; if1.cin = 1'b0; if1.a = '0; if1.b = '0;
        #2;
        // reset state
        chk("rst_ready", 64'(if4.ready), 64'd1);
        chk("rst_busy",  64'(if4.busy),  64'd0);
        chk("rst_done",  64'(if4.done),  64'd0);
        chk("rst_sum",   64'(if4.sum),   64'd0);
        chk("rst_cout",  64'(if4.cout),  64'd0);
        chk("rst_err",   64'(if4.err),   64'd0);
        chk("rst_seg",   64'(if4.seg),   64'h7_FFFF_FFFF);
        chk("rst_seg1",  64'(if1.seg),   64'h3FFF);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: 1234 + 5678 + 1 = 6913
        start_op4(16'h1234, 16'h5678, 1'b1);
        chk("t1_busy", 64'(if4.busy), 64'd1);
        chk("t1_ready_busy", 64'(if4.ready), 64'd0);
        wait_done4(n);
        chk("t1_latency", 64'(n), 64'd4);
        chk("t1_sum",  64'(if4.sum),  64'h6913);
        chk("t1_cout", 64'(if4.cout), 64'd0);
        chk("t1_err",  64'(if4.err),  64'd0);
        chk("t1_seg",  64'(if4.seg),  64'({7'h40, 7'h02, 7'h10, 7'h79, 7'h30}));
        chk("t1_ready_done", 64'(if4.ready), 64'd1);
        tick();
        chk("t1_done_pulse", 64'(if4.done), 64'd0);
        chk("t1_sum_held", 64'(if4.sum), 64'h6913);

        // 2: 9999 + 0000 + 1 = 1_0000
        start_op4(16'h9999, 16'h0000, 1'b1);
        wait_done4(n);
        chk("t2_latency", 64'(n), 64'd4);
        chk("t2_sum",  64'(if4.sum),  64'h0000);
        chk("t2_cout", 64'(if4.cout), 64'd1);
        chk("t2_seg",  64'(if4.seg),  64'({7'h79, 7'h40, 7'h40, 7'h40, 7'h40}));
        tick();

        // 3: non-BCD nibble in digit 1 of a
        start_op4(16'h00A0, 16'h0001, 1'b0);
        wait_done4(n);
        chk("t3_err", 64'(if4.err), 64'd1);
        chk("t3_sum_bcd_digits", 64'(if4.sum & 16'hFF0F), 64'h0101);
        chk("t3_cout", 64'(if4.cout), 64'd0);
        chk("t3_seg", 64'(if4.seg), 64'({7'h40, 7'h40, 7'h79, 7'h06, 7'h79}));
        tick();

        // 4: start held high, back-to-back operations
        if4.a = 16'h0001; if4.b = 16'h0002; if4.cin = 1'b0; if4.start = 1'b1;
        tick();
        chk("t4_busy1", 64'(if4.busy), 64'd1);
        if4.a = 16'h5000; if4.b = 16'h5000;
        wait_done4(n);
        chk("t4_lat1", 64'(n), 64'd4);
        chk("t4_sum1", 64'(if4.sum), 64'h0003);
        chk("t4_cout1", 64'(if4.cout), 64'd0);
        chk("t4_err1", 64'(if4.err), 64'd0);
        tick();
        chk("t4_busy2", 64'(if4.busy), 64'd1);
        chk("t4_done_low", 64'(if4.done), 64'd0);
        if4.a = 16'h0999; if4.b = 16'h0001;
        wait_done4(n);
        chk("t4_lat2", 64'(n), 64'd4);
        chk("t4_sum2", 64'(if4.sum), 64'h0000);
        chk("t4_cout2", 64'(if4.cout), 64'd1);
        chk("t4_seg2", 64'(if4.seg), 64'({7'h79, 7'h40, 7'h40, 7'h40, 7'h40}));
        tick();
        if4.start = 1'b0;
        wait_done4(n);
        chk("t4_lat3", 64'(n), 64'd4);
        chk("t4_sum3", 64'(if4.sum), 64'h1000);
        chk("t4_cout3", 64'(if4.cout), 64'd0);
        chk("t4_seg3", 64'(if4.seg), 64'({7'h40, 7'h79, 7'h40, 7'h40, 7'h40}));
        tick();
        chk("t4_idle", 64'(if4.ready), 64'd1);

        // 5: reset in the middle of an operation
        start_op4(16'h1111, 16'h2222, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        chk("t5_ready", 64'(if4.ready), 64'd1);
        chk("t5_busy",  64'(if4.busy),  64'd0);
        chk("t5_done",  64'(if4.done),  64'd0);
        chk("t5_sum",   64'(if4.sum),   64'd0);
        chk("t5_cout",  64'(if4.cout),  64'd0);
        chk("t5_seg",   64'(if4.seg),   64'h7_FFFF_FFFF);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if4.done) seen++;
        end
        chk("t5_no_done", 64'(seen), 64'd0);
        start_op4(16'h4321, 16'h1234, 1'b0);
        wait_done4(n);
        chk("t5_lat_after", 64'(n), 64'd4);
        chk("t5_sum_after", 64'(if4.sum), 64'h5555);
        tick();

        // 6: single-digit instance, 7 + 8 = 15
        if1.a = 4'h7; if1.b = 4'h8; if1.cin = 1'b0; if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!if1.done && n < 10);
        chk("t6_latency", 64'(n), 64'd1);
        chk("t6_sum",  64'(if1.sum),  64'h5);
        chk("t6_cout", 64'(if1.cout), 64'd1);
        chk("t6_err",  64'(if1.err),  64'd0);
        chk("t6_seg",  64'(if1.seg),  64'({7'h79, 7'h12}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
